// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_sequencer_pkg;

  localparam int          INST_W     = 32;
  localparam logic [31:0] PC_STEP    = 32'd4;
  localparam logic [1:0]  ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_BUBBLE = 2'd1,
    ST_HALT   = 2'd2
  } fetch_state_t;

  // Word-aligned when the byte-offset bits are all zero.
  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_holding_buffer.sv
// One-entry valid/ready holding register with flush, usable between any two
// pipeline stages. Flush beats load, load beats the downstream accept.
module fetch_holding_buffer
  import fetch_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              flush,
  input  logic              ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [31:0]       in_pc,
  output logic              valid,
  output logic [INST_W-1:0] inst,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4
);

  // Buffer entry: reload on load, drop on flush or when consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid    <= 1'b0;
      inst     <= '0;
      pc       <= '0;
      pc_plus4 <= PC_STEP;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid    <= 1'b1;
      inst     <= in_inst;
      pc       <= in_pc;
      pc_plus4 <= in_pc + PC_STEP;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, feeds the combinational
// instruction memory and hands words to decode through a holding buffer.
//
//   state     | meaning
//   ST_RUN    | fetching one word per free buffer slot
//   ST_BUBBLE | post-redirect penalty, counting down before fetch resumes
//   ST_HALT   | stopped on PC limit or misaligned target; left only by reset
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC         = 32'h0000_0000,
  parameter logic [31:0] PC_LIMIT         = 32'h0000_00FC,
  parameter int          REDIRECT_BUBBLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic [31:0]       imem_pc,
  input  logic [INST_W-1:0] imem_inst,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [INST_W-1:0] if_inst,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_pc_plus4,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_target,
  output logic              halt,
  output logic              fault,
  output logic [31:0]       fetch_count
);

  localparam logic       HAS_BUBBLE  = (REDIRECT_BUBBLES != 0);
  localparam logic [2:0] BUBBLE_INIT = HAS_BUBBLE ? 3'(REDIRECT_BUBBLES - 1) : 3'd0;

  fetch_state_t state;
  logic [31:0]  pc;
  logic [2:0]   bubble_cnt;

  logic redirect_act;
  logic fetch_slot;
  logic capture;
  logic limit_hit;

  // A fetch slot exists when running, not being redirected, and the buffer
  // is empty or being drained this cycle. The limit check gates the slot.
  always_comb begin
    redirect_act = redirect_valid && (state != ST_HALT);
    fetch_slot   = (state == ST_RUN) && !redirect_valid && (!if_valid || if_ready);
    capture      = fetch_slot && (pc <= PC_LIMIT);
    limit_hit    = fetch_slot && (pc > PC_LIMIT);
  end

  assign imem_pc = pc;

  // Sequencer state, program counter, bubble timer and sticky status.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_RUN;
      pc          <= RESET_PC;
      bubble_cnt  <= 3'd0;
      halt        <= 1'b0;
      fault       <= 1'b0;
      fetch_count <= '0;
    end else if (redirect_act) begin
      if (!is_aligned(redirect_target)) begin
        fault <= 1'b1;
        state <= ST_HALT;
      end else begin
        pc <= redirect_target;
        if (HAS_BUBBLE) begin
          state      <= ST_BUBBLE;
          bubble_cnt <= BUBBLE_INIT;
        end else begin
          state <= ST_RUN;
        end
      end
    end else begin
      unique case (state)
        ST_RUN: begin
          if (capture) begin
            pc          <= pc + PC_STEP;
            fetch_count <= fetch_count + 32'd1;
          end else if (limit_hit) begin
            halt  <= 1'b1;
            state <= ST_HALT;
          end
        end
        ST_BUBBLE: begin
          if (bubble_cnt == 3'd0) state <= ST_RUN;
          else                    bubble_cnt <= bubble_cnt - 3'd1;
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: state <= ST_HALT;
      endcase
    end
  end

  fetch_holding_buffer u_buf (
    .clk      (clk),
    .reset    (reset),
    .load     (capture),
    .flush    (redirect_act),
    .ready    (if_ready),
    .in_inst  (imem_inst),
    .in_pc    (pc),
    .valid    (if_valid),
    .inst     (if_inst),
    .pc       (if_pc),
    .pc_plus4 (if_pc_plus4)
  );

endmodule
